// File: rtl/fb_writer.sv
// Framebuffer write side: packs pairs of 16-bit pixels into 32-bit SRAM words and writes them
// through a request/grant handshake. Define FB_WRITER_CLEAR_EN to add the framebuffer clear pass.
module fb_writer #(
  parameter int H_PIXELS = 600,
  parameter int V_PIXELS = 600,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              clear_req,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [15:0]       pix_data,
  input  logic              pix_last,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic              sram_grant,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  localparam logic [19:0] LAST_IDX = 20'(H_PIXELS * V_PIXELS - 1);

  logic [1:0]  state;
  logic [19:0] cnt;
  logic [15:0] low;
  logic        started;
  logic        accept;
  logic        is_last;

`ifdef FB_WRITER_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_PIXELS * V_PIXELS / 2 - 1);
  logic [ADDR_W-1:0] clr_addr;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
`endif

  // sram_write doubles as the pending flag, so no pixel is taken while a word waits for grant
  assign pix_ready = (state == S_STREAM) && !sram_write;
  assign accept    = pix_valid && pix_ready && !frame_start;
  assign is_last   = pix_last || (cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      low        <= '0;
      started    <= 1'b0;
      sram_write <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
`ifdef FB_WRITER_CLEAR_EN
      clr_addr   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        // A new frame aborts whatever is in flight, including a partly packed word
        sram_write <= 1'b0;
        cnt        <= '0;
        low        <= '0;
        overrun    <= 1'b0;
        started    <= 1'b1;
`ifdef FB_WRITER_CLEAR_EN
        clr_addr   <= '0;
        state      <= clear_req ? S_CLEAR : S_STREAM;
`else
        state      <= S_STREAM;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (started && pix_valid)
              overrun <= 1'b1;
          end
`ifdef FB_WRITER_CLEAR_EN
          S_CLEAR: begin
            if (!sram_write) begin
              sram_write <= 1'b1;
              sram_addr  <= clr_addr;
              sram_wdata <= '0;
            end else if (sram_grant) begin
              sram_write <= 1'b0;
              if (clr_addr == CLR_LAST) begin
                state <= S_STREAM;
                cnt   <= '0;
              end else begin
                clr_addr <= clr_addr + 1'b1;
              end
            end
          end
`endif
          S_STREAM: begin
            if (sram_write && sram_grant)
              sram_write <= 1'b0;
            if (accept) begin
              cnt <= cnt + 1'b1;
              if (!cnt[0])
                low <= pix_data;
              // An odd pixel completes a word; a final even pixel goes out with a transparent partner
              if (cnt[0] || is_last) begin
                sram_write <= 1'b1;
                sram_addr  <= ADDR_W'(cnt >> 1);
                sram_wdata <= cnt[0] ? {pix_data, low} : {16'h0000, pix_data};
              end
              if (is_last)
                state <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            if (sram_write && sram_grant) begin
              sram_write <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer, built with a 6x4 frame so the full-frame pass stays short.
module tb_fb_writer;

  localparam int H  = 6;
  localparam int V  = 4;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          clear_req;
  logic          pix_valid;
  logic          pix_ready;
  logic [15:0]   pix_data;
  logic          pix_last;
  logic          sram_write;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic          sram_grant;
  logic          frame_done;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    bit          start;
    logic [15:0] pix;
    bit          last;
    bit          emit;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_done) done_cnt++;

  fb_writer #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .clear_req(clear_req),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
    .sram_write(sram_write), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_grant(sram_grant), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one pixel and holds it until accepted (bounded)
  task automatic applyStimulus(input logic [15:0] d, input logic last);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    for (int n = 0; n < 20 && !pix_ready; n++) tick();
    if (!pix_ready) checkOutput("accept_timeout", {31'b0, pix_ready}, 32'd1);
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic waitWrite(output logic [31:0] a, output logic [31:0] d);
    for (int n = 0; n < 20 && !(sram_write && sram_grant); n++) tick();
    checkOutput("write_seen", {31'b0, sram_write && sram_grant}, 32'd1);
    a = 32'(sram_addr);
    d = sram_wdata;
    tick();
  endtask

  task automatic startFrame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_sram_write"}, {31'b0, sram_write}, 32'd0);
    checkOutput({tag, "_pix_ready"},  {31'b0, pix_ready},  32'd0);
    checkOutput({tag, "_frame_done"}, {31'b0, frame_done}, 32'd0);
    checkOutput({tag, "_overrun"},    {31'b0, overrun},    32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [15:0] pv, prev;

    rst = 1'b1; frame_start = 1'b0; clear_req = 1'b0; pix_valid = 1'b0;
    pix_data = '0; pix_last = 1'b0; sram_grant = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkIdleOutputs("reset");
    checkOutput("reset_addr",  32'(sram_addr), 32'd0);
    checkOutput("reset_wdata", sram_wdata, 32'd0);

    // Packing frame (aborted by the next frame_start), then an early pix_last on an even index
    vecs[0] = '{1'b1, 16'h01AA, 1'b0, 1'b0, 32'd0, 32'h0};
    vecs[1] = '{1'b0, 16'h0155, 1'b0, 1'b1, 32'd0, 32'h015501AA};
    vecs[2] = '{1'b0, 16'h0080, 1'b0, 1'b0, 32'd0, 32'h0};
    vecs[3] = '{1'b0, 16'h01FF, 1'b0, 1'b1, 32'd1, 32'h01FF0080};
    vecs[4] = '{1'b1, 16'h0101, 1'b0, 1'b0, 32'd0, 32'h0};
    vecs[5] = '{1'b0, 16'h0102, 1'b0, 1'b1, 32'd0, 32'h01020101};
    vecs[6] = '{1'b0, 16'h0103, 1'b1, 1'b1, 32'd1, 32'h00000103};
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].start) startFrame();
      applyStimulus(vecs[i].pix, vecs[i].last);
      if (vecs[i].emit) begin
        waitWrite(a, d);
        checkOutput($sformatf("vec%0d_addr", i), a, vecs[i].addr);
        checkOutput($sformatf("vec%0d_data", i), d, vecs[i].data);
      end
    end
    checkOutput("early_last_done", {31'b0, frame_done}, 32'd1);
    tick();
    checkOutput("early_last_done_pulse", {31'b0, frame_done}, 32'd0);
    checkOutput("early_last_done_count", 32'(done_cnt), 32'd1);
    checkOutput("early_last_ready", {31'b0, pix_ready}, 32'd0);

    // Write held by the arbiter for five cycles
    startFrame();
    sram_grant = 1'b0;
    applyStimulus(16'h1234, 1'b0);
    applyStimulus(16'h5678, 1'b0);
    for (int n = 0; n < 5; n++) begin
      checkOutput("stall_write", {31'b0, sram_write}, 32'd1);
      checkOutput("stall_addr",  32'(sram_addr), 32'd0);
      checkOutput("stall_data",  sram_wdata, 32'h56781234);
      checkOutput("stall_ready", {31'b0, pix_ready}, 32'd0);
      tick();
    end
    sram_grant = 1'b1;
    tick();
    checkOutput("grant_drop_write", {31'b0, sram_write}, 32'd0);
    checkOutput("grant_ready_back", {31'b0, pix_ready}, 32'd1);

    // Reset in the middle of a stalled write
    sram_grant = 1'b0;
    applyStimulus(16'h0AB0, 1'b0);
    applyStimulus(16'h0AB1, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    sram_grant = 1'b1;
    checkIdleOutputs("midreset");
    pix_valid = 1'b1;
    tick();
    checkOutput("midreset_no_overrun", {31'b0, overrun}, 32'd0);
    pix_valid = 1'b0;

    // Abort after one pixel discards the latched low half
    startFrame();
    applyStimulus(16'h0111, 1'b0);
    startFrame();
    applyStimulus(16'h0222, 1'b0);
    applyStimulus(16'h0333, 1'b0);
    waitWrite(a, d);
    checkOutput("abort_addr", a, 32'd0);
    checkOutput("abort_data", d, 32'h03330222);

    // frame_start wins over a pixel accepted in the same cycle
    pix_valid = 1'b1; pix_data = 16'h0AAA; frame_start = 1'b1;
    tick();
    pix_valid = 1'b0; frame_start = 1'b0;
    applyStimulus(16'h0001, 1'b0);
    applyStimulus(16'h0002, 1'b0);
    waitWrite(a, d);
    checkOutput("collide_addr", a, 32'd0);
    checkOutput("collide_data", d, 32'h00020001);

    // Full frame with no pix_last: ends on the pixel count
    startFrame();
    prev = '0;
    for (int i = 0; i < H * V; i++) begin
      pv = 16'(16'h0100 + i);
      applyStimulus(pv, 1'b0);
      if (i % 2 == 1) begin
        waitWrite(a, d);
        checkOutput($sformatf("full_addr%0d", i), a, 32'(i / 2));
        checkOutput($sformatf("full_data%0d", i), d, {pv, prev});
      end
      prev = pv;
    end
    checkOutput("full_done", {31'b0, frame_done}, 32'd1);
    pix_valid = 1'b1;
    pix_data  = 16'hBEEF;
    tick();
    checkOutput("full_ready_low", {31'b0, pix_ready}, 32'd0);
    checkOutput("full_no_extra_write", {31'b0, sram_write}, 32'd0);
    checkOutput("full_done_count", 32'(done_cnt), 32'd2);
    tick();
    checkOutput("overrun_set", {31'b0, overrun}, 32'd1);
    pix_valid = 1'b0;
    tick();
    checkOutput("overrun_sticky", {31'b0, overrun}, 32'd1);
    startFrame();
    checkOutput("overrun_cleared", {31'b0, overrun}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
